// File: rtl/tetris_pkg.sv
// Shared Tetris constants: playfield geometry and 640x480@60 VGA timing.
package tetris_pkg;

  localparam int GRID_ROWS     = 22;
  localparam int GRID_COLS     = 10;
  localparam int VIS_ROW_FIRST = 1;
  localparam int VIS_ROW_LAST  = 20;
  localparam int VIS_ROWS      = VIS_ROW_LAST - VIS_ROW_FIRST + 1;

  localparam int H_VIS  = 640;
  localparam int H_FP   = 16;
  localparam int H_SYNC = 96;
  localparam int H_BP   = 48;
  localparam int V_VIS  = 480;
  localparam int V_FP   = 10;
  localparam int V_SYNC = 2;
  localparam int V_BP   = 33;

  localparam int H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;

endpackage

// File: rtl/vga_timing.sv
// Free-running 800x525 raster counters with raw (unregistered) sync,
// visible and frame-start flags.
module vga_timing
  import tetris_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  output logic [9:0] hcnt,
  output logic [9:0] vcnt,
  output logic       hsync_raw,
  output logic       vsync_raw,
  output logic       visible,
  output logic       frame_flag
);

  localparam logic [9:0] H_LAST       = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST       = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS_END    = 10'(H_VIS);
  localparam logic [9:0] V_VIS_END    = 10'(V_VIS);
  localparam logic [9:0] H_SYNC_START = 10'(H_VIS + H_FP);
  localparam logic [9:0] H_SYNC_END   = 10'(H_VIS + H_FP + H_SYNC);
  localparam logic [9:0] V_SYNC_START = 10'(V_VIS + V_FP);
  localparam logic [9:0] V_SYNC_END   = 10'(V_VIS + V_FP + V_SYNC);

  // vcnt advances only on the last pixel of a line
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hcnt <= '0;
      vcnt <= '0;
    end else if (hcnt == H_LAST) begin
      hcnt <= '0;
      vcnt <= (vcnt == V_LAST) ? '0 : vcnt + 10'd1;
    end else begin
      hcnt <= hcnt + 10'd1;
    end
  end

  assign hsync_raw  = !((hcnt >= H_SYNC_START) && (hcnt < H_SYNC_END));
  assign vsync_raw  = !((vcnt >= V_SYNC_START) && (vcnt < V_SYNC_END));
  assign visible    = (hcnt < H_VIS_END) && (vcnt < V_VIS_END);
  assign frame_flag = (hcnt == 10'd0) && (vcnt == 10'd0);

endmodule

// File: rtl/tetris_vga_render.sv
// Draws the Tetris playfield on 640x480 VGA from a grid snapshot that is
// refreshed once per frame during vertical blank.
module tetris_vga_render
  import tetris_pkg::*;
#(
  parameter int          CELL_PX = 16,
  parameter int          X0      = 240,
  parameter int          Y0      = 80,
  parameter logic [11:0] FG      = 12'hF80,
  parameter logic [11:0] BG      = 12'h111,
  parameter logic [11:0] BORDER  = 12'h888
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [GRID_COLS-1:0] grid [GRID_ROWS-1:0],
  output logic                 hsync,
  output logic                 vsync,
  output logic [11:0]          rgb,
  output logic                 frame_start
);

  localparam int         SH    = $clog2(CELL_PX);
  localparam logic [9:0] BX0   = 10'(X0);
  localparam logic [9:0] BX1   = 10'(X0 + GRID_COLS * CELL_PX);
  localparam logic [9:0] BY0   = 10'(Y0);
  localparam logic [9:0] BY1   = 10'(Y0 + VIS_ROWS * CELL_PX);
  localparam logic [9:0] RING  = 10'd4;
  localparam logic [9:0] CMASK = 10'(CELL_PX - 1);

  logic [9:0] hcnt, vcnt;
  logic       hsync_raw, vsync_raw, visible, frame_flag;

  vga_timing u_timing (
    .clk        (clk),
    .rst        (rst),
    .hcnt       (hcnt),
    .vcnt       (vcnt),
    .hsync_raw  (hsync_raw),
    .vsync_raw  (vsync_raw),
    .visible    (visible),
    .frame_flag (frame_flag)
  );

  logic [GRID_COLS-1:0] snap [VIS_ROWS];
  logic                 snap_load;
  logic                 unused_rows;

  assign snap_load   = (hcnt == 10'd0) && (vcnt == 10'(V_VIS));
  // Spawn and floor rows are never drawn.
  assign unused_rows = ^{grid[0], grid[GRID_ROWS-1]};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int r = 0; r < VIS_ROWS; r++) snap[r] <= '0;
    end else if (snap_load) begin
      for (int r = 0; r < VIS_ROWS; r++) snap[r] <= grid[r + VIS_ROW_FIRST];
    end
  end

  logic [9:0]  dx, dy;
  logic [4:0]  row;
  logic [3:0]  col;
  logic        in_board, in_ring, outline, cell_bit;
  logic [11:0] pix;

  // dx/dy only matter inside the board, where they cannot wrap
  always_comb begin
    dx       = hcnt - BX0;
    dy       = vcnt - BY0;
    col      = 4'(dx >> SH);
    row      = 5'(dy >> SH);
    in_board = (hcnt >= BX0) && (hcnt < BX1) && (vcnt >= BY0) && (vcnt < BY1);
    in_ring  = (hcnt + RING >= BX0) && (hcnt < BX1 + RING) &&
               (vcnt + RING >= BY0) && (vcnt < BY1 + RING);
    outline  = ((dx & CMASK) == CMASK) || ((dy & CMASK) == CMASK);
    cell_bit = 1'b0;
    if (in_board) cell_bit = snap[row][col];
    pix = 12'h000;
    if (!visible)     pix = 12'h000;
    else if (in_board) pix = (cell_bit && !outline) ? FG : BG;
    else if (in_ring)  pix = BORDER;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hsync       <= 1'b1;
      vsync       <= 1'b1;
      rgb         <= 12'h000;
      frame_start <= 1'b0;
    end else begin
      hsync       <= hsync_raw;
      vsync       <= vsync_raw;
      rgb         <= pix;
      frame_start <= frame_flag;
    end
  end

endmodule

// File: tb/tb_tetris_vga_render.sv
// Scoreboard bench for tetris_vga_render: per-cycle expectations from a
// raster/playfield reference model, raster position jumped by forcing counters.
`timescale 1ns/1ps
module tb_tetris_vga_render;

  localparam int          CELL     = 16;
  localparam int          BX0      = 240;
  localparam int          BY0      = 80;
  localparam logic [11:0] C_FG     = 12'hF80;
  localparam logic [11:0] C_BG     = 12'h111;
  localparam logic [11:0] C_BORDER = 12'h888;

  logic        clk = 1'b0;
  logic        rst;
  logic [9:0]  grid [21:0];
  logic        hsync, vsync, frame_start;
  logic [11:0] rgb;

  typedef struct {
    int          x;
    int          y;
    bit          chk;
    logic        hs;
    logic        vs;
    logic [11:0] rgb;
    logic        fs;
  } exp_t;

  exp_t       sbq[$];
  int         checks = 0;
  int         errors = 0;
  int         mh, mv;
  logic [9:0] msnap   [20];
  logic [9:0] fix_val [22];
  bit         fix_en  [22];
  bit         jump_pend;
  int         jh, jv;
  bit         wide_chk;

  tetris_vga_render #(
    .CELL_PX (CELL),
    .X0      (BX0),
    .Y0      (BY0),
    .FG      (C_FG),
    .BG      (C_BG),
    .BORDER  (C_BORDER)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .grid        (grid),
    .hsync       (hsync),
    .vsync       (vsync),
    .rgb         (rgb),
    .frame_start (frame_start)
  );

  always #20 clk = ~clk;

  function automatic logic [11:0] ref_rgb(int x, int y);
    int col, row;
    if (x >= 640 || y >= 480) return 12'h000;
    if (x >= BX0 && x < BX0 + 10*CELL && y >= BY0 && y < BY0 + 20*CELL) begin
      col = (x - BX0) / CELL;
      row = (y - BY0) / CELL;
      if (!msnap[row][col]) return C_BG;
      if ((x - BX0) % CELL == CELL-1 || (y - BY0) % CELL == CELL-1) return C_BG;
      return C_FG;
    end
    if (x >= BX0-4 && x < BX0 + 10*CELL + 4 && y >= BY0-4 && y < BY0 + 20*CELL + 4)
      return C_BORDER;
    return 12'h000;
  endfunction

  function automatic bit interesting_x(int x);
    return x inside {0, 1, 235, 236, 239, 240, 241, 254, 255, 256, 257, 399, 400,
                     403, 404, 405, 638, 639, 640, 641, 655, 656, 657, 751, 752,
                     753, 798, 799};
  endfunction

  task automatic jump(int h, int v);
    jh = h;
    jv = v;
    jump_pend = 1'b1;
  endtask

  task automatic reset_model();
    mh = 0;
    mv = 0;
    for (int r = 0; r < 20; r++) msnap[r] = '0;
  endtask

  // One cycle per iteration: drive grid, push the expectation for the next edge
  task automatic applyStimulus(int n);
    for (int i = 0; i < n; i++) begin
      exp_t e;
      @(negedge clk);
      if (jump_pend) begin
        force dut.u_timing.hcnt = 10'(jh);
        force dut.u_timing.vcnt = 10'(jv);
        #1;
        release dut.u_timing.hcnt;
        release dut.u_timing.vcnt;
        mh = jh;
        mv = jv;
        jump_pend = 1'b0;
      end
      for (int r = 1; r <= 20; r++) grid[r] = fix_en[r] ? fix_val[r] : 10'($urandom);
      e.x   = mh;
      e.y   = mv;
      e.hs  = !(mh >= 656 && mh < 752);
      e.vs  = !(mv >= 490 && mv < 492);
      e.rgb = ref_rgb(mh, mv);
      e.fs  = (mh == 0 && mv == 0);
      e.chk = interesting_x(mh) || (wide_chk && mh >= 232 && mh <= 408) ||
              ($urandom_range(0, 15) == 0);
      sbq.push_back(e);
      if (mh == 0 && mv == 480)
        for (int r = 0; r < 20; r++) msnap[r] = grid[r+1];
      if (mh == 799) begin
        mh = 0;
        mv = (mv == 524) ? 0 : mv + 1;
      end else begin
        mh = mh + 1;
      end
    end
  endtask

  task automatic checkOutput(string name, logic hs, logic vs, logic [11:0] c, logic fs);
    checks++;
    if (hsync !== hs || vsync !== vs || rgb !== c || frame_start !== fs) begin
      errors++;
      $display("[TB] FAIL %s: got hs=%b vs=%b rgb=%h fs=%b, want hs=%b vs=%b rgb=%h fs=%b",
               name, hsync, vsync, rgb, frame_start, hs, vs, c, fs);
    end
  endtask

  // Monitor: every output edge pops the matching expectation
  initial begin
    exp_t m;
    forever begin
      @(posedge clk);
      #1;
      if (sbq.size() > 0) begin
        m = sbq.pop_front();
        if (m.chk) begin
          checks++;
          if (hsync !== m.hs || vsync !== m.vs || rgb !== m.rgb || frame_start !== m.fs) begin
            errors++;
            $display("[TB] FAIL pix(%0d,%0d): got hs=%b vs=%b rgb=%h fs=%b, want hs=%b vs=%b rgb=%h fs=%b",
                     m.x, m.y, hsync, vsync, rgb, frame_start, m.hs, m.vs, m.rgb, m.fs);
          end
        end
      end
    end
  end

  initial begin
    rst = 1'b1;
    jump_pend = 1'b0;
    wide_chk = 1'b0;
    for (int r = 0; r < 22; r++) begin
      grid[r] = '0;
      fix_en[r] = 1'b0;
      fix_val[r] = '0;
    end
    grid[0]  = 10'h3FF;
    grid[21] = 10'h3FF;
    reset_model();
    #1 rst = 1'b0;
    #4 checkOutput("reset_initial", 1'b1, 1'b1, 12'h000, 1'b0);
    @(posedge clk);
    #5 rst = 1'b1;
    reset_model();
    $display("[TB] frame start after reset, first lines");
    applyStimulus(2*800 + 10);
    jump(0, 85);
    applyStimulus(800);

    $display("[TB] asynchronous reset inside sync pulses");
    jump(690, 490);
    applyStimulus(20);
    @(posedge clk);
    #5 rst = 1'b0;
    #1 checkOutput("reset_async", 1'b1, 1'b1, 12'h000, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #1 checkOutput("reset_hold", 1'b1, 1'b1, 12'h000, 1'b0);
    #4 rst = 1'b1;
    reset_model();
    applyStimulus(10);

    $display("[TB] snapshot with single cell in row 1");
    fix_en[1] = 1'b1;  fix_val[1] = 10'b0000000001;
    fix_en[5] = 1'b1;  fix_val[5] = 10'h000;
    jump(795, 479);
    applyStimulus(10);
    fix_en[1] = 1'b0;
    jump(795, 524);
    applyStimulus(10);
    wide_chk = 1'b1;
    jump(0, 76);
    applyStimulus(22*800);
    jump(0, 126);
    applyStimulus(5*800);

    $display("[TB] grid row 5 filled mid-frame");
    jump(0, 200);
    fix_val[5] = 10'h3FF;
    applyStimulus(2*800);
    jump(0, 142);
    applyStimulus(4*800);
    jump(0, 395);
    applyStimulus(11*800);
    wide_chk = 1'b0;

    $display("[TB] next frame after snapshot");
    jump(600, 479);
    applyStimulus(250);
    jump(795, 524);
    applyStimulus(10);
    wide_chk = 1'b1;
    jump(0, 142);
    applyStimulus(4*800);
    wide_chk = 1'b0;

    $display("[TB] vertical sync window");
    jump(790, 489);
    applyStimulus(3*800 + 20);

    @(posedge clk);
    #2;
    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("[TB] FAIL scoreboard_drain: got %0d pending, want 0", sbq.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
